// File: rtl/kbd_ctrl.sv
// Keyboard hotkey controller: turns PS/2 key events into warm/cold reset,
// scandoubler and turbo controls, with typematic repeats suppressed.
module kbd_ctrl #(
  parameter int RSTLEN = 1024,
  parameter bit VGA0   = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strb,
  input  logic       make,
  input  logic [7:0] code,
  output logic       warmn,
  output logic       coldn,
  output logic       vga,
  output logic       speed
);

  localparam int            CW       = $clog2(RSTLEN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RSTLEN - 1);

  localparam int K_LCTRL = 0;
  localparam int K_LALT  = 1;
  localparam int K_DEL   = 2;
  localparam int K_BKSP  = 3;
  localparam int K_F9    = 4;
  localparam int K_F12   = 5;
  localparam int K_SCRL  = 6;

  typedef enum logic {ST_IDLE, ST_PULSE} pulse_st_e;

  logic [6:0]    key_hit, press;
  logic [6:0]    held_q, held_d;
  pulse_st_e     warm_st_q, warm_st_d, cold_st_q, cold_st_d;
  logic [CW-1:0] warm_cnt_q, warm_cnt_d, cold_cnt_q, cold_cnt_d;
  logic          warm_trig, cold_trig;
  logic          vga_q, vga_d, speed_q, speed_d;
  logic          warmn_q, warmn_d, coldn_q, coldn_d;

  always_comb begin
    key_hit = '0;
    case (code)
      8'h14:   key_hit[K_LCTRL] = 1'b1;
      8'h11:   key_hit[K_LALT]  = 1'b1;
      8'h71:   key_hit[K_DEL]   = 1'b1;
      8'h66:   key_hit[K_BKSP]  = 1'b1;
      8'h01:   key_hit[K_F9]    = 1'b1;
      8'h07:   key_hit[K_F12]   = 1'b1;
      8'h7E:   key_hit[K_SCRL]  = 1'b1;
      default: key_hit = '0;
    endcase
  end

  // A press edge is a make for a key not already held; repeats are filtered here.
  always_comb begin
    press     = {7{strb & make}} & key_hit & ~held_q;
    held_d    = held_q;
    if (strb) held_d = make ? (held_q | key_hit) : (held_q & ~key_hit);
    warm_trig = press[K_DEL]  & held_q[K_LCTRL] & held_q[K_LALT];
    cold_trig = press[K_BKSP] & held_q[K_LCTRL] & held_q[K_LALT];
    vga_d     = vga_q ^ press[K_SCRL];
    speed_d   = speed_q ^ press[K_F12];
  end

  always_comb begin
    warm_st_d  = warm_st_q;
    warm_cnt_d = warm_cnt_q;
    case (warm_st_q)
      ST_IDLE: if (warm_trig) begin
        warm_st_d  = ST_PULSE;
        warm_cnt_d = CNT_LOAD;
      end
      ST_PULSE: begin
        if (warm_trig)              warm_cnt_d = CNT_LOAD;
        else if (warm_cnt_q == '0)  warm_st_d  = ST_IDLE;
        else                        warm_cnt_d = warm_cnt_q - 1'b1;
      end
      default: warm_st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cold_st_d  = cold_st_q;
    cold_cnt_d = cold_cnt_q;
    case (cold_st_q)
      ST_IDLE: if (cold_trig) begin
        cold_st_d  = ST_PULSE;
        cold_cnt_d = CNT_LOAD;
      end
      ST_PULSE: begin
        if (cold_trig)              cold_cnt_d = CNT_LOAD;
        else if (cold_cnt_q == '0)  cold_st_d  = ST_IDLE;
        else                        cold_cnt_d = cold_cnt_q - 1'b1;
      end
      default: cold_st_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state so they move on the edge after the strobe.
  always_comb begin
    coldn_d = (cold_st_d != ST_PULSE);
    warmn_d = !((warm_st_d == ST_PULSE) || (cold_st_d == ST_PULSE) || held_d[K_F9]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      held_q     <= '0;
      warm_st_q  <= ST_IDLE;
      cold_st_q  <= ST_IDLE;
      warm_cnt_q <= '0;
      cold_cnt_q <= '0;
      vga_q      <= VGA0;
      speed_q    <= 1'b0;
      warmn_q    <= 1'b1;
      coldn_q    <= 1'b1;
    end else begin
      held_q     <= held_d;
      warm_st_q  <= warm_st_d;
      cold_st_q  <= cold_st_d;
      warm_cnt_q <= warm_cnt_d;
      cold_cnt_q <= cold_cnt_d;
      vga_q      <= vga_d;
      speed_q    <= speed_d;
      warmn_q    <= warmn_d;
      coldn_q    <= coldn_d;
    end
  end

  assign warmn = warmn_q;
  assign coldn = coldn_q;
  assign vga   = vga_q;
  assign speed = speed_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Bench for kbd_ctrl: directed hotkey scenarios plus random key traffic,
// checked every cycle against a remaining-cycles reference model.
module tb_kbd_ctrl;

  localparam int RSTLEN = 1024;
  localparam bit VGA0   = 1'b1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       strb  = 1'b0;
  logic       make  = 1'b0;
  logic [7:0] code  = 8'h00;
  logic       warmn, coldn, vga, speed;

  kbd_ctrl #(.RSTLEN(RSTLEN), .VGA0(VGA0)) dut (
    .clock(clock), .reset(reset), .strb(strb), .make(make), .code(code),
    .warmn(warmn), .coldn(coldn), .vga(vga), .speed(speed)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;
  int low_w  = 0;
  int low_c  = 0;

  // Reference model: pressed keys by code, remaining low cycles per pulse.
  bit m_held [256];
  int warm_rem = 0;
  int cold_rem = 0;
  bit m_vga    = VGA0;
  bit m_speed  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit tracked(input logic [7:0] c);
    return (c == 8'h14) || (c == 8'h11) || (c == 8'h71) || (c == 8'h66) ||
           (c == 8'h01) || (c == 8'h07) || (c == 8'h7E);
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic m, input logic [7:0] c);
    if (!r) begin
      for (int i = 0; i < 256; i++) m_held[i] = 1'b0;
      warm_rem = 0;
      cold_rem = 0;
      m_vga    = VGA0;
      m_speed  = 1'b0;
    end else begin
      if (warm_rem > 0) warm_rem--;
      if (cold_rem > 0) cold_rem--;
      if (s && tracked(c)) begin
        if (m && !m_held[c]) begin
          if (c == 8'h7E) m_vga   = !m_vga;
          if (c == 8'h07) m_speed = !m_speed;
          if (c == 8'h71 && m_held[8'h14] && m_held[8'h11]) warm_rem = RSTLEN;
          if (c == 8'h66 && m_held[8'h14] && m_held[8'h11]) cold_rem = RSTLEN;
        end
        m_held[c] = m;
      end
    end
  endtask

  // One clock cycle: drive inputs, advance model at the edge, compare 1 ns later.
  task automatic cyc(input logic r, input logic s, input logic m, input logic [7:0] c);
    reset = r; strb = s; make = m; code = c;
    @(posedge clock);
    model_edge(r, s, m, c);
    #1;
    chk("warmn", warmn, !(warm_rem > 0 || cold_rem > 0 || m_held[8'h01]));
    chk("coldn", coldn, !(cold_rem > 0));
    chk("vga",   vga,   m_vga);
    chk("speed", speed, m_speed);
    if (warmn === 1'b0) low_w++;
    if (coldn === 1'b0) low_c++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic key(input logic m, input logic [7:0] c);
    cyc(1'b1, 1'b1, m, c);
  endtask

  initial begin
    logic [7:0] klist [8];
    klist = '{8'h14, 8'h11, 8'h71, 8'h66, 8'h01, 8'h07, 8'h7E, 8'h00};

    // Reset state and first ScrollLock toggle
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_vga", vga, 1'b1);
    chk("rst_speed", speed, 1'b0);
    chk("rst_warmn", warmn, 1'b1);
    chk("rst_coldn", coldn, 1'b1);
    idle(2);
    key(1'b1, 8'h7E);
    chk("scrl_toggle", vga, 1'b0);

    // Typematic repeats toggle only once
    key(1'b0, 8'h7E);
    for (int i = 0; i < 5; i++) key(1'b1, 8'h7E);
    chk("scrl_repeat", vga, 1'b1);
    key(1'b0, 8'h7E);
    key(1'b1, 8'h7E);
    chk("scrl_again", vga, 1'b0);
    key(1'b0, 8'h7E);

    // Ctrl+Alt+Del warm pulse
    key(1'b1, 8'h14);
    key(1'b1, 8'h11);
    low_w = 0; low_c = 0;
    key(1'b1, 8'h71);
    idle(1100);
    chk("warm_len", low_w, RSTLEN);
    chk("warm_cold", low_c, 0);
    key(1'b0, 8'h71);
    key(1'b0, 8'h11);
    key(1'b0, 8'h14);

    // Ctrl+Alt+Backspace, re-triggered 500 cycles later
    key(1'b1, 8'h11);
    key(1'b1, 8'h14);
    low_w = 0; low_c = 0;
    key(1'b1, 8'h66);
    key(1'b0, 8'h14);
    key(1'b0, 8'h11);
    key(1'b0, 8'h66);
    key(1'b1, 8'h14);
    key(1'b1, 8'h11);
    idle(494);
    key(1'b1, 8'h66);
    idle(1100);
    chk("cold_len", low_c, 500 + RSTLEN);
    chk("cold_warm_len", low_w, 500 + RSTLEN);
    key(1'b0, 8'h66);
    key(1'b0, 8'h11);
    key(1'b0, 8'h14);

    // Del without modifiers, then F9 hold
    low_w = 0;
    key(1'b1, 8'h71);
    idle(10);
    chk("del_alone", low_w, 0);
    key(1'b0, 8'h71);
    key(1'b0, 8'h55);
    low_w = 0;
    key(1'b1, 8'h01);
    idle(2999);
    key(1'b0, 8'h01);
    idle(5);
    chk("f9_len", low_w, 3000);

    // Reset aborts a warm pulse; pending F9 break afterwards is harmless
    key(1'b1, 8'h7E);
    key(1'b0, 8'h7E);
    key(1'b1, 8'h01);
    key(1'b1, 8'h14);
    key(1'b1, 8'h11);
    key(1'b1, 8'h71);
    idle(99);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("abort_warmn", warmn, 1'b1);
    chk("abort_vga", vga, VGA0);
    idle(3);
    key(1'b0, 8'h01);
    chk("f9_glitch", warmn, 1'b1);
    idle(3);

    // Random key traffic with occasional reset
    for (int i = 0; i < 6000; i++) begin
      logic       r, s, m;
      logic [7:0] c;
      r = ($urandom_range(0, 499) != 0);
      s = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 1) == 1);
      c = klist[$urandom_range(0, 7)];
      if (c == 8'h00) c = 8'($urandom_range(0, 255));
      cyc(r, s, m, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
